// File: rtl/player_ctl_if.sv
// Player controller bus: frame tick, key levels and collision flags in;
// player centre position and ground flag out.
//   master : game side (drives ticks/keys/collision flags, reads position)
//   slave  : player_ctl
interface player_ctl_if;
  localparam int unsigned PW = 10;

  logic          frame_tick;
  logic          key_left;
  logic          key_right;
  logic          key_jump;
  logic          collision_up;
  logic          collision_down;
  logic          collision_left;
  logic          collision_right;
  logic [PW-1:0] xpos;
  logic [PW-1:0] ypos;
  logic          on_ground;

  modport master (
    output frame_tick, key_left, key_right, key_jump,
    output collision_up, collision_down, collision_left, collision_right,
    input  xpos, ypos, on_ground
  );

  modport slave (
    input  frame_tick, key_left, key_right, key_jump,
    input  collision_up, collision_down, collision_left, collision_right,
    output xpos, ypos, on_ground
  );
endinterface

// File: rtl/player_ctl.sv
// Per-frame player motion controller: turns key levels into the player
// centre (xpos, ypos) under gravity/jump dynamics, gated by collision flags.
// Ports:
//   clk   : system clock
//   rst_n : asynchronous active-low reset
//   pif   : player_ctl_if.slave (frame_tick, keys, collision flags in;
//           xpos, ypos, on_ground out, all registered)
module player_ctl #(
  parameter int unsigned SIZE    = 16,
  parameter int unsigned X_START = 320,
  parameter int unsigned Y_START = 100,
  parameter int unsigned STEP    = 2,
  parameter int unsigned JUMP_V  = 8,
  parameter int unsigned GRAVITY = 1,
  parameter int unsigned VMAX    = 8,
  parameter int unsigned X_MIN   = 0,
  parameter int unsigned X_MAX   = 799,
  parameter int unsigned Y_MIN   = 0,
  parameter int unsigned Y_MAX   = 599
) (
  input  logic          clk,
  input  logic          rst_n,
  player_ctl_if.slave   pif
);

  localparam int unsigned PW = 10;
  localparam int unsigned CW = 11;
  localparam int unsigned VW = 4;

  // Position limits and step sizes widened so comparisons cannot wrap
  localparam logic [CW-1:0] X_LO   = CW'(X_MIN + SIZE);
  localparam logic [CW-1:0] X_HI   = CW'(X_MAX - SIZE);
  localparam logic [CW-1:0] Y_LO   = CW'(Y_MIN + SIZE);
  localparam logic [CW-1:0] Y_HI   = CW'(Y_MAX - SIZE);
  localparam logic [CW-1:0] STEP_C = CW'(STEP);
  localparam logic [VW-1:0] JUMP_C = VW'(JUMP_V);
  localparam logic [VW-1:0] GRAV_C = VW'(GRAVITY);
  localparam logic [VW:0]   GRAV_W = (VW+1)'(GRAVITY);
  localparam logic [VW:0]   VMAX_W = (VW+1)'(VMAX);

  typedef enum logic [1:0] {GROUND, RISE, FALL} state_e;

  state_e        state_q, state_d;
  logic [VW-1:0] vy_q, vy_d;
  logic [PW-1:0] xpos_q, xpos_d;
  logic [PW-1:0] ypos_q, ypos_d;
  logic          on_ground_q, on_ground_d;
  logic          jump_req_q, jump_req_d;
  logic          key_jump_q, key_jump_d;

  logic          jump_edge;
  logic          jump_now;
  logic [CW-1:0] x_ext;
  logic [CW-1:0] y_ext;
  logic [CW-1:0] vy_ext;
  logic [CW-1:0] x_sum;
  logic [CW-1:0] y_sum;
  logic [VW:0]   vy_inc;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= FALL;
      vy_q        <= '0;
      xpos_q      <= PW'(X_START);
      ypos_q      <= PW'(Y_START);
      on_ground_q <= 1'b0;
      jump_req_q  <= 1'b0;
      key_jump_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      vy_q        <= vy_d;
      xpos_q      <= xpos_d;
      ypos_q      <= ypos_d;
      on_ground_q <= on_ground_d;
      jump_req_q  <= jump_req_d;
      key_jump_q  <= key_jump_d;
    end
  end

  // Next-state: jump latch every cycle, motion only on frame_tick
  always_comb begin
    state_d     = state_q;
    vy_d        = vy_q;
    xpos_d      = xpos_q;
    ypos_d      = ypos_q;
    on_ground_d = on_ground_q;
    key_jump_d  = pif.key_jump;

    jump_edge   = pif.key_jump & ~key_jump_q;
    jump_now    = jump_req_q | jump_edge;
    // A tick always consumes the request, even one arriving on the same edge
    jump_req_d  = pif.frame_tick ? 1'b0 : jump_now;

    x_ext  = {1'b0, xpos_q};
    y_ext  = {1'b0, ypos_q};
    vy_ext = CW'(vy_q);
    x_sum  = x_ext + STEP_C;
    y_sum  = y_ext + vy_ext;
    vy_inc = {1'b0, vy_q} + GRAV_W;

    if (pif.frame_tick) begin
      // Horizontal move, clamped to the screen edges
      if (pif.key_left && !pif.key_right && !pif.collision_left) begin
        if (x_ext < X_LO + STEP_C) xpos_d = PW'(X_LO);
        else                       xpos_d = PW'(x_ext - STEP_C);
      end else if (pif.key_right && !pif.key_left && !pif.collision_right) begin
        if (x_sum > X_HI) xpos_d = PW'(X_HI);
        else              xpos_d = PW'(x_sum);
      end

      // Vertical move
      unique case (state_q)
        GROUND: begin
          if (!pif.collision_down) begin
            state_d = FALL;
            vy_d    = '0;
          end else if (jump_now) begin
            state_d = RISE;
            vy_d    = JUMP_C;
          end
        end
        RISE: begin
          if (pif.collision_up || vy_q == '0) begin
            state_d = FALL;
            vy_d    = '0;
          end else if (y_ext < Y_LO + vy_ext) begin
            // Rearranged from ypos-vy < Y_LO so the subtraction never underflows
            ypos_d  = PW'(Y_LO);
            state_d = FALL;
            vy_d    = '0;
          end else begin
            ypos_d = PW'(y_ext - vy_ext);
            vy_d   = (vy_q > GRAV_C) ? vy_q - GRAV_C : '0;
          end
        end
        FALL: begin
          if (pif.collision_down) begin
            state_d = GROUND;
            vy_d    = '0;
          end else if (y_sum >= Y_HI) begin
            ypos_d  = PW'(Y_HI);
            state_d = GROUND;
            vy_d    = '0;
          end else begin
            ypos_d = PW'(y_sum);
            vy_d   = (vy_inc >= VMAX_W) ? VW'(VMAX_W) : VW'(vy_inc);
          end
        end
        default: begin
          state_d = FALL;
          vy_d    = '0;
        end
      endcase

      on_ground_d = (state_d == GROUND);
    end
  end

  assign pif.xpos      = xpos_q;
  assign pif.ypos      = ypos_q;
  assign pif.on_ground = on_ground_q;

endmodule

// File: tb/tb_player_ctl.sv
// Directed bench for player_ctl with a queue of expected (xpos, ypos, on_ground).
module tb_player_ctl;

  typedef struct {
    string      tag;
    logic [9:0] x;
    logic [9:0] y;
    logic       g;
  } exp_t;

  logic clk;
  logic rst_n;
  int   tests;
  int   fails;
  exp_t sb[$];

  // Bench-side models
  int mx, my, mvy;
  bit mg;

  player_ctl_if pif ();

  player_ctl dut (
    .clk   (clk),
    .rst_n (rst_n),
    .pif   (pif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic push(input string tag, input int x, input int y, input bit g);
    exp_t e;
    e.tag = tag;
    e.x   = 10'(x);
    e.y   = 10'(y);
    e.g   = g;
    sb.push_back(e);
  endtask

  task automatic check_pop();
    exp_t e;
    if (sb.size() == 0) begin
      tests++;
      fails++;
      $error("FAIL sb_empty: observed output with no expected entry, required an entry");
      return;
    end
    e = sb.pop_front();
    tests++;
    assert (pif.xpos === e.x) else begin
      fails++;
      $error("FAIL %s xpos: got %0d expected %0d", e.tag, pif.xpos, e.x);
    end
    tests++;
    assert (pif.ypos === e.y) else begin
      fails++;
      $error("FAIL %s ypos: got %0d expected %0d", e.tag, pif.ypos, e.y);
    end
    tests++;
    assert (pif.on_ground === e.g) else begin
      fails++;
      $error("FAIL %s on_ground: got %0b expected %0b", e.tag, pif.on_ground, e.g);
    end
  endtask

  // One frame_tick pulse; returns at the falling edge after the tick edge
  task automatic tick(input bit with_jump_edge);
    @(negedge clk);
    pif.frame_tick = 1'b1;
    if (with_jump_edge) pif.key_jump = 1'b1;
    @(negedge clk);
    pif.frame_tick = 1'b0;
  endtask

  task automatic step(input string tag, input int x, input int y, input bit g);
    push(tag, x, y, g);
    tick(1'b0);
    check_pop();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    tests = 0;
    fails = 0;
    rst_n = 1'b0;
    pif.frame_tick      = 1'b0;
    pif.key_left        = 1'b0;
    pif.key_right       = 1'b0;
    pif.key_jump        = 1'b0;
    pif.collision_up    = 1'b0;
    pif.collision_down  = 1'b0;
    pif.collision_left  = 1'b0;
    pif.collision_right = 1'b0;

    // Reset state
    #12;
    push("reset", 320, 100, 0);
    check_pop();
    @(negedge clk);
    rst_n = 1'b1;

    // Free fall from rest: 100, 101, 103, 106, 110
    step("fall1", 320, 100, 0);
    step("fall2", 320, 101, 0);
    step("fall3", 320, 103, 0);
    step("fall4", 320, 106, 0);
    step("fall5", 320, 110, 0);

    // Landing and holding on ground
    pif.collision_down = 1'b1;
    step("land", 320, 110, 1);
    step("ground_hold", 320, 110, 1);

    // Jump: RISE with ypos held, then -8, -7, ... -1
    pif.key_jump = 1'b1;
    step("jump_start", 320, 110, 0);
    my = 110;
    for (int v = 8; v >= 1; v--) begin
      my = my - v;
      step("rise", 320, my, 0);
    end
    step("apex_fall", 320, 74, 0);
    step("reland", 320, 74, 1);
    // Key still held: no second jump
    step("no_rejump1", 320, 74, 1);
    step("no_rejump2", 320, 74, 1);

    // Second jump, hit the ceiling on the second RISE tick
    pif.key_jump = 1'b0;
    @(negedge clk);
    pif.key_jump = 1'b1;
    step("jump2_start", 320, 74, 0);
    step("jump2_rise", 320, 66, 0);
    pif.collision_up = 1'b1;
    step("ceiling", 320, 66, 0);
    pif.collision_up   = 1'b0;
    pif.collision_down = 1'b0;
    pif.key_jump       = 1'b0;
    step("ceil_hold", 320, 66, 0);
    step("ceil_fall", 320, 67, 0);

    // Left run clamps at X_MIN+SIZE
    pif.collision_down = 1'b1;
    pif.key_left       = 1'b1;
    mx = 320;
    for (int i = 0; i < 200; i++) begin
      mx = (mx - 2 < 16) ? 16 : mx - 2;
      step("left_run", mx, 67, 1);
    end
    pif.key_right = 1'b1;
    step("both_keys", 16, 67, 1);
    pif.key_left = 1'b0;
    step("right_one", 18, 67, 1);
    pif.key_right      = 1'b0;
    pif.key_left       = 1'b1;
    pif.collision_left = 1'b1;
    step("coll_left", 18, 67, 1);
    pif.key_left       = 1'b0;
    pif.collision_left = 1'b0;

    // Right run clamps at X_MAX-SIZE
    pif.key_right = 1'b1;
    mx = 18;
    for (int i = 0; i < 400; i++) begin
      mx = (mx + 2 > 783) ? 783 : mx + 2;
      step("right_run", mx, 67, 1);
    end
    pif.key_right = 1'b0;

    // No tick, no change
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      pif.key_left       = i[0];
      pif.key_right      = ~i[0];
      pif.collision_down = i[1];
      pif.collision_up   = i[0];
    end
    @(negedge clk);
    push("no_tick", 783, 67, 1);
    check_pop();
    pif.key_left       = 1'b0;
    pif.key_right      = 1'b0;
    pif.collision_up   = 1'b0;
    pif.collision_down = 1'b0;

    // No terrain: fall to the floor clamp at Y_MAX-SIZE
    my = 67; mvy = 0; mg = 1'b1;
    for (int i = 0; i < 90; i++) begin
      if (mg) begin
        mg = 1'b0; mvy = 0;
      end else if (my + mvy >= 583) begin
        my = 583; mg = 1'b1; mvy = 0;
      end else begin
        my  = my + mvy;
        mvy = (mvy + 1 > 8) ? 8 : mvy + 1;
      end
      step("floor", 783, my, mg);
    end

    // Asynchronous reset mid-fall
    do_reset();
    pif.key_right = 1'b1;
    step("rfall1", 322, 100, 0);
    step("rfall2", 324, 101, 0);
    step("rfall3", 326, 103, 0);
    pif.key_right = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    push("async_reset", 320, 100, 0);
    check_pop();
    @(negedge clk);
    rst_n = 1'b1;

    // Jump edge coinciding with tick in GROUND starts a jump
    pif.collision_down = 1'b1;
    step("cg_land", 320, 100, 1);
    push("coinc_ground", 320, 100, 0);
    tick(1'b1);
    check_pop();
    step("coinc_rise", 320, 92, 0);

    // Jump edge coinciding with tick in FALL is discarded
    pif.key_jump       = 1'b0;
    pif.collision_down = 1'b0;
    do_reset();
    push("coinc_fall", 320, 100, 0);
    tick(1'b1);
    check_pop();
    pif.collision_down = 1'b1;
    step("cf_land", 320, 100, 1);
    step("cf_no_jump", 320, 100, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
